oet_sort_unit: RTL and testbench
================================

// Module: oet_sort_unit
// PURPOSE
//  Iterative odd-even transposition sorter for an N-element window of BIT_WIDTH-bit samples.
//  It is the parametrised successor of the fixed 9-sample sorter in the median filter datapath.
//  Sorts ascending or descending and returns the full sorted vector plus the median element.
//  Uses valid/ready handshakes on input and output. Sits between the window line-buffer and the pixel writer.
// PARAMETERS
//  BIT_WIDTH   8  sample width in bits (>=1)
//  N           9  elements per window (>=2)
//  EARLY_EXIT  0  1 = stop SORT once two consecutive phases perform no swap
// PORTS
//  CLK          in   1            clock, rising edge
//  RST          in   1            reset, asynchronous, active-low
//  in_valid_i   in   1            input vector valid
//  in_ready_o   out  1            block can accept a vector (high only in IDLE)
//  in_data_i    in   N*BIT_WIDTH  packed input; element k = [k*BIT_WIDTH +: BIT_WIDTH]
//  desc_i       in   1            0 = ascending, 1 = descending; sampled at accept
//  out_valid_o  out  1            sorted result valid (high only in DONE)
//  out_ready_i  in   1            consumer accepts result
//  out_data_o   out  N*BIT_WIDTH  sorted vector, same packing as the input; element 0 = first
//  median_o     out  BIT_WIDTH    sorted element at index (N-1)/2
//  busy_o       out  1            high in SORT
// BEHAVIOUR
//  Reset: state=IDLE. All data regs, phase counter, mode reg and flags = 0.
//   in_ready_o=1, out_valid_o=0, busy_o=0, out_data_o=0, median_o=0.
//  FSM states: IDLE, SORT, DONE. Outputs are decoded from the state only.
//  IDLE: in_ready_o=1. On in_valid_i & in_ready_o:
//   - latch in_data_i and desc_i
//   - phase=0
//   - go to SORT.
//  SORT: one phase per cycle; all pairs in the phase are compare-exchanged in parallel.
//   - Even phase: pairs (0,1),(2,3),...
//   - Odd phase: pairs (1,2),(3,4),...
//   - Odd N: the unpaired last element holds.
//   - Exchange happens only on strict order violation: a>b when ascending, a<b when descending.
//     Equal values never swap.
//   - phase increments every cycle.
//   - EARLY_EXIT=0: the cycle with phase==N-1 is the last SORT cycle; go to DONE.
//     SORT lasts exactly N cycles.
//   - EARLY_EXIT=1: also go to DONE after any phase in which neither it nor the previous phase
//     swapped. The phase==0 check uses only its own swap flag together with phase>=1,
//     so the minimum is 2 phases.
//  Latency, EARLY_EXIT=0: accept at edge t -> out_valid_o rises after edge t+N.
//   in_ready_o returns 1 the cycle after the output handshake.
//  DONE: out_valid_o=1. out_data_o and median_o stay stable until out_valid_o & out_ready_i,
//   then go to IDLE. Data regs keep their value in IDLE; outputs always show the data regs.
//   No new input is accepted in SORT or DONE (in_ready_o=0).
//  Simultaneous events: in_valid_i during SORT/DONE is ignored; the producer must hold it.
//   out_ready_i outside DONE is ignored.
//  Reset mid-operation: immediate return to the reset state. The partial vector is discarded.
//  Width rules:
//   - compares are unsigned
//   - phase counter width = $clog2(N+1), saturating is not needed since it is cleared on accept
//   - median index = (N-1)/2, integer divide; for even N this is the lower-middle element.
// STRUCTURE
//  Shared header common.vh:
//   - default BIT_WIDTH/N macros
//   - FSM encodings IDLE=2'b00, SORT=2'b01, DONE=2'b10
//  Sub-module cmp_exchange: parametrised BIT_WIDTH, combinational.
//   - inputs: a, b, desc
//   - outputs: lo, hi, swapped
//   - generate-instantiated floor(N/2) times for the even phase and floor((N-1)/2) times for
//     the odd phase. Mux selects the phase result into the data regs.
//  Top: FSM, phase counter, swap-history flag, data regs, output decode.
// TESTING
//  1 N=9, ascending, input 9,8,7,6,5,4,3,2,1 (element0 first):
//    out_data_o=1..9, median_o=5, out_valid_o exactly 9 cycles after accept.
//  2 N=9, desc_i=1, input 3,200,17,17,0,255,64,1,99:
//    out_data_o=255,200,99,64,17,17,3,1,0, median_o=17; the equal 17s produce no swap.
//  3 EARLY_EXIT=1, N=9, already-sorted 0..8:
//    DONE after 2 SORT cycles, data unchanged, median_o=4.
//  4 Backpressure: hold out_ready_i=0 for 5 cycles in DONE.
//    Outputs stable, in_ready_o=0, and a new in_valid_i is not taken.
//    Release -> IDLE next cycle, then accept.
//  5 Reset: assert RST low at SORT phase 4. Within the same cycle all outputs go to reset values
//    and in_ready_o=1. A fresh vector after release sorts correctly.
//  6 N=4, BIT_WIDTH=12, input 4095,0,2048,2048:
//    out=0,2048,2048,4095, median_o=2048 (index 1), latency 4 cycles.

Source files
------------

// File: rtl/oet_sort_unit_pkg.sv
// Shared definitions for the odd-even transposition sorter: default sizes,
// FSM encodings and the median index helper.
package oet_sort_unit_pkg;

   localparam int DEFAULT_BIT_WIDTH = 8;
   localparam int DEFAULT_N         = 9;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_SORT = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   // For even window sizes this picks the lower-middle element.
   function automatic int median_index(input int n);
      return (n - 1) / 2;
   endfunction

endpackage

// File: rtl/oet_sort_unit_cmp_exchange.sv
// Compare-exchange cell: lo goes to the lower index, hi to the upper one.
// Swaps only on a strict order violation, so equal values stay put.
module cmp_exchange #(
   parameter int BIT_WIDTH = 8
) (
   input  logic [BIT_WIDTH-1:0] a,
   input  logic [BIT_WIDTH-1:0] b,
   input  logic                 desc,
   output logic [BIT_WIDTH-1:0] lo,
   output logic [BIT_WIDTH-1:0] hi,
   output logic                 swapped
);

   assign swapped = desc ? (a < b) : (a > b);
   assign lo      = swapped ? b : a;
   assign hi      = swapped ? a : b;

endmodule

// File: rtl/oet_sort_unit.sv
// Iterative odd-even transposition sorter with valid/ready handshakes,
// returning the sorted window and its median element.
module oet_sort_unit
   import oet_sort_unit_pkg::*;
#(
   parameter int BIT_WIDTH  = DEFAULT_BIT_WIDTH,
   parameter int N          = DEFAULT_N,
   parameter int EARLY_EXIT = 0
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [N*BIT_WIDTH-1:0] in_data_i,
   input  logic                   desc_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [N*BIT_WIDTH-1:0] out_data_o,
   output logic [BIT_WIDTH-1:0]   median_o,
   output logic                   busy_o
);

   localparam int PW  = $clog2(N + 1);
   localparam int MID = median_index(N);
   localparam int NE  = N / 2;
   localparam int NO  = (N - 1) / 2;
   localparam int NOW = (NO > 0) ? NO : 1;
   localparam logic [PW-1:0] LAST_PHASE = PW'(N - 1);

   logic [1:0]           state_q;
   logic [PW-1:0]        phase_q;
   logic                 desc_q;
   logic                 prev_swap_q;
   logic [BIT_WIDTH-1:0] data_q [N];
   logic [BIT_WIDTH-1:0] even_d [N];
   logic [BIT_WIDTH-1:0] odd_d  [N];
   logic [NE-1:0]        even_sw;
   logic [NOW-1:0]       odd_sw;
   logic                 phase_swap;
   logic                 finish_sort;

   // Even phase network: pairs (0,1),(2,3),...
   for (genvar i = 0; i < NE; i++) begin : g_even
      cmp_exchange #(.BIT_WIDTH(BIT_WIDTH)) u_cx (
         .a       (data_q[2*i]),
         .b       (data_q[2*i+1]),
         .desc    (desc_q),
         .lo      (even_d[2*i]),
         .hi      (even_d[2*i+1]),
         .swapped (even_sw[i])
      );
   end
   if (N % 2 == 1) begin : g_even_tail
      assign even_d[N-1] = data_q[N-1];
   end

   // Odd phase network: pairs (1,2),(3,4),... with element 0 passing through.
   for (genvar i = 0; i < NO; i++) begin : g_odd
      cmp_exchange #(.BIT_WIDTH(BIT_WIDTH)) u_cx (
         .a       (data_q[2*i+1]),
         .b       (data_q[2*i+2]),
         .desc    (desc_q),
         .lo      (odd_d[2*i+1]),
         .hi      (odd_d[2*i+2]),
         .swapped (odd_sw[i])
      );
   end
   assign odd_d[0] = data_q[0];
   if (N % 2 == 0) begin : g_odd_tail
      assign odd_d[N-1] = data_q[N-1];
   end
   if (NO == 0) begin : g_odd_none
      assign odd_sw = '0;
   end

   assign phase_swap  = phase_q[0] ? (|odd_sw) : (|even_sw);
   // Early exit needs two quiet phases back to back, so never before phase 1.
   assign finish_sort = (phase_q == LAST_PHASE) ||
                        ((EARLY_EXIT != 0) && (phase_q != '0) && !phase_swap && !prev_swap_q);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= ST_IDLE;
         phase_q     <= '0;
         desc_q      <= 1'b0;
         prev_swap_q <= 1'b0;
         for (int k = 0; k < N; k++) data_q[k] <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid_i) begin
                  for (int k = 0; k < N; k++) data_q[k] <= in_data_i[k*BIT_WIDTH +: BIT_WIDTH];
                  desc_q      <= desc_i;
                  phase_q     <= '0;
                  prev_swap_q <= 1'b0;
                  state_q     <= ST_SORT;
               end
            end
            ST_SORT: begin
               for (int k = 0; k < N; k++) data_q[k] <= phase_q[0] ? odd_d[k] : even_d[k];
               phase_q     <= phase_q + 1'b1;
               prev_swap_q <= phase_swap;
               if (finish_sort) state_q <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready_i) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready_o  = (state_q == ST_IDLE);
   assign busy_o      = (state_q == ST_SORT);
   assign out_valid_o = (state_q == ST_DONE);
   assign median_o    = data_q[MID];

   always_comb begin
      out_data_o = '0;
      for (int k = 0; k < N; k++) out_data_o[k*BIT_WIDTH +: BIT_WIDTH] = data_q[k];
   end

endmodule

// File: tb/tb_oet_sort_unit.sv
// Bench for oet_sort_unit: three instances (N=9, N=9 with early exit, N=4 x 12 bit)
// checked against a queue-sort reference model.
module tb_oet_sort_unit;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   logic        a_in_valid = 1'b0, a_desc = 1'b0, a_out_ready = 1'b0;
   logic        a_in_ready, a_out_valid, a_busy;
   logic [71:0] a_in_data = '0, a_out_data;
   logic [7:0]  a_median;

   logic        e_in_valid = 1'b0, e_desc = 1'b0, e_out_ready = 1'b0;
   logic        e_in_ready, e_out_valid, e_busy;
   logic [71:0] e_in_data = '0, e_out_data;
   logic [7:0]  e_median;

   logic        f_in_valid = 1'b0, f_desc = 1'b0, f_out_ready = 1'b0;
   logic        f_in_ready, f_out_valid, f_busy;
   logic [47:0] f_in_data = '0, f_out_data;
   logic [11:0] f_median;

   oet_sort_unit #(.BIT_WIDTH(8), .N(9), .EARLY_EXIT(0)) dut_a (
      .CLK(CLK), .RST(RST), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
      .in_data_i(a_in_data), .desc_i(a_desc), .out_valid_o(a_out_valid),
      .out_ready_i(a_out_ready), .out_data_o(a_out_data), .median_o(a_median), .busy_o(a_busy)
   );

   oet_sort_unit #(.BIT_WIDTH(8), .N(9), .EARLY_EXIT(1)) dut_e (
      .CLK(CLK), .RST(RST), .in_valid_i(e_in_valid), .in_ready_o(e_in_ready),
      .in_data_i(e_in_data), .desc_i(e_desc), .out_valid_o(e_out_valid),
      .out_ready_i(e_out_ready), .out_data_o(e_out_data), .median_o(e_median), .busy_o(e_busy)
   );

   oet_sort_unit #(.BIT_WIDTH(12), .N(4), .EARLY_EXIT(0)) dut_f (
      .CLK(CLK), .RST(RST), .in_valid_i(f_in_valid), .in_ready_o(f_in_ready),
      .in_data_i(f_in_data), .desc_i(f_desc), .out_valid_o(f_out_valid),
      .out_ready_i(f_out_ready), .out_data_o(f_out_data), .median_o(f_median), .busy_o(f_busy)
   );

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain queue sort of the unpacked elements.
   function automatic logic [71:0] ref_sort(input logic [71:0] v, input int n, input int bw,
                                            input bit desc);
      int          q[$];
      logic [71:0] r;
      logic [71:0] mask;
      mask = (72'd1 << bw) - 72'd1;
      r    = '0;
      for (int k = 0; k < n; k++) q.push_back(int'((v >> (k * bw)) & mask));
      if (desc) q.rsort();
      else      q.sort();
      for (int k = 0; k < n; k++) r = r | (72'(q[k]) << (k * bw));
      return r;
   endfunction

   function automatic int elems(input int which);
      return (which == 2) ? 4 : 9;
   endfunction

   function automatic int width(input int which);
      return (which == 2) ? 12 : 8;
   endfunction

   function automatic logic get_out_valid(input int which);
      case (which)
         0:       return a_out_valid;
         1:       return e_out_valid;
         default: return f_out_valid;
      endcase
   endfunction

   function automatic logic get_in_ready(input int which);
      case (which)
         0:       return a_in_ready;
         1:       return e_in_ready;
         default: return f_in_ready;
      endcase
   endfunction

   function automatic logic [71:0] get_out_data(input int which);
      case (which)
         0:       return a_out_data;
         1:       return e_out_data;
         default: return 72'(f_out_data);
      endcase
   endfunction

   function automatic logic [71:0] get_median(input int which);
      case (which)
         0:       return 72'(a_median);
         1:       return 72'(e_median);
         default: return 72'(f_median);
      endcase
   endfunction

   function automatic logic [71:0] pack9(input int v[9]);
      logic [71:0] r;
      r = '0;
      for (int k = 0; k < 9; k++) r[k*8 +: 8] = v[k][7:0];
      return r;
   endfunction

   function automatic logic [71:0] rand_vec(input int which);
      logic [71:0] r;
      int          bw;
      bw = width(which);
      r  = '0;
      for (int k = 0; k < elems(which); k++) begin
         if ($urandom_range(0, 1) == 1) r = r | (72'($urandom_range(0, 7)) << (k * bw));
         else r = r | (72'($urandom_range(0, (1 << bw) - 1)) << (k * bw));
      end
      return r;
   endfunction

   // Present one vector, confirm the block is ready, and let it be accepted.
   task automatic apply_stimulus(input int which, input logic [71:0] vec, input bit desc);
      @(negedge CLK);
      case (which)
         0: begin a_in_data = vec;       a_desc = desc; a_in_valid = 1'b1; end
         1: begin e_in_data = vec;       e_desc = desc; e_in_valid = 1'b1; end
         default: begin f_in_data = vec[47:0]; f_desc = desc; f_in_valid = 1'b1; end
      endcase
      check("in_ready_before_accept", 72'(get_in_ready(which)), 72'd1);
      @(posedge CLK);
      #1;
      a_in_valid = 1'b0;
      e_in_valid = 1'b0;
      f_in_valid = 1'b0;
   endtask

   task automatic wait_done(input int which, output int cycles);
      cycles = 0;
      while (!get_out_valid(which) && cycles < 40) begin
         @(posedge CLK);
         #1;
         cycles++;
      end
      check("out_valid_within_bound", 72'(get_out_valid(which)), 72'd1);
   endtask

   // Compare the result with the model, then complete the output handshake.
   task automatic check_output(input int which, input string tag, input logic [71:0] vec,
                               input bit desc);
      logic [71:0] exp;
      logic [71:0] mask;
      int          mid;
      mid  = (elems(which) - 1) / 2;
      mask = (72'd1 << width(which)) - 72'd1;
      exp  = ref_sort(vec, elems(which), width(which), desc);
      check({tag, "_data"},   get_out_data(which), exp);
      check({tag, "_median"}, get_median(which), (exp >> (mid * width(which))) & mask);
      @(negedge CLK);
      a_out_ready = (which == 0);
      e_out_ready = (which == 1);
      f_out_ready = (which == 2);
      @(posedge CLK);
      #1;
      a_out_ready = 1'b0;
      e_out_ready = 1'b0;
      f_out_ready = 1'b0;
      check({tag, "_valid_drop"}, 72'(get_out_valid(which)), 72'd0);
      check({tag, "_ready_back"}, 72'(get_in_ready(which)), 72'd1);
   endtask

   initial begin
      int          cycles;
      int          t1[9];
      int          t2[9];
      int          t3[9];
      logic [71:0] vec;
      logic [71:0] vec2;
      bit          d;

      t1 = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
      t2 = '{3, 200, 17, 17, 0, 255, 64, 1, 99};
      t3 = '{0, 1, 2, 3, 4, 5, 6, 7, 8};

      $display("[TB] reset state");
      repeat (2) @(negedge CLK);
      check("rst_in_ready",  72'(a_in_ready),  72'd1);
      check("rst_out_valid", 72'(a_out_valid), 72'd0);
      check("rst_busy",      72'(a_busy),      72'd0);
      check("rst_out_data",  a_out_data,       72'd0);
      check("rst_median",    72'(a_median),    72'd0);
      check("rst_f_data",    72'(f_out_data),  72'd0);
      RST = 1'b1;

      $display("[TB] descending-input ascending sort");
      vec = pack9(t1);
      apply_stimulus(0, vec, 1'b0);
      check("t1_busy",     72'(a_busy),     72'd1);
      check("t1_in_ready", 72'(a_in_ready), 72'd0);
      wait_done(0, cycles);
      check("t1_latency", 72'(cycles), 72'd9);
      check("t1_median_const", 72'(a_median), 72'd5);
      check_output(0, "t1", vec, 1'b0);

      $display("[TB] descending sort with duplicates");
      vec = pack9(t2);
      apply_stimulus(0, vec, 1'b1);
      wait_done(0, cycles);
      check("t2_latency", 72'(cycles), 72'd9);
      check("t2_median_const", 72'(a_median), 72'd17);
      check_output(0, "t2", vec, 1'b1);

      $display("[TB] early exit on sorted input");
      vec = pack9(t3);
      apply_stimulus(1, vec, 1'b0);
      wait_done(1, cycles);
      check("t3_cycles", 72'(cycles), 72'd2);
      check("t3_unchanged", e_out_data, vec);
      check("t3_median_const", 72'(e_median), 72'd4);
      check_output(1, "t3", vec, 1'b0);

      $display("[TB] output backpressure");
      vec  = rand_vec(0);
      vec2 = rand_vec(0);
      apply_stimulus(0, vec, 1'b0);
      wait_done(0, cycles);
      @(negedge CLK);
      a_in_data  = vec2;
      a_desc     = 1'b1;
      a_in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK);
         #1;
         check("bp_out_valid", 72'(a_out_valid), 72'd1);
         check("bp_in_ready",  72'(a_in_ready),  72'd0);
         check("bp_stable",    a_out_data, ref_sort(vec, 9, 8, 1'b0));
      end
      @(negedge CLK);
      a_out_ready = 1'b1;
      @(posedge CLK);
      #1;
      a_out_ready = 1'b0;
      check("bp_idle_ready", 72'(a_in_ready),  72'd1);
      check("bp_idle_valid", 72'(a_out_valid), 72'd0);
      @(posedge CLK);
      #1;
      a_in_valid = 1'b0;
      check("bp_accept_busy", 72'(a_busy), 72'd1);
      wait_done(0, cycles);
      check("bp_latency", 72'(cycles), 72'd9);
      check_output(0, "bp", vec2, 1'b1);

      $display("[TB] reset mid-sort");
      vec = rand_vec(0);
      apply_stimulus(0, vec, 1'b0);
      repeat (4) @(posedge CLK);
      #1;
      RST = 1'b0;
      #1;
      check("mrst_in_ready",  72'(a_in_ready),  72'd1);
      check("mrst_out_valid", 72'(a_out_valid), 72'd0);
      check("mrst_busy",      72'(a_busy),      72'd0);
      check("mrst_out_data",  a_out_data,       72'd0);
      check("mrst_median",    72'(a_median),    72'd0);
      @(negedge CLK);
      RST = 1'b1;
      vec = rand_vec(0);
      apply_stimulus(0, vec, 1'b1);
      wait_done(0, cycles);
      check("mrst_latency", 72'(cycles), 72'd9);
      check_output(0, "mrst", vec, 1'b1);

      $display("[TB] N=4 12-bit window");
      vec = 72'({12'd2048, 12'd2048, 12'd0, 12'd4095});
      apply_stimulus(2, vec, 1'b0);
      wait_done(2, cycles);
      check("t6_latency", 72'(cycles), 72'd4);
      check("t6_median_const", 72'(f_median), 72'd2048);
      check_output(2, "t6", vec, 1'b0);

      $display("[TB] random vectors");
      for (int i = 0; i < 12; i++) begin
         vec = rand_vec(0);
         d   = 1'($urandom_range(0, 1));
         apply_stimulus(0, vec, d);
         wait_done(0, cycles);
         check("rnd_a_latency", 72'(cycles), 72'd9);
         check_output(0, "rnd_a", vec, d);
      end
      for (int i = 0; i < 12; i++) begin
         vec = rand_vec(1);
         d   = 1'($urandom_range(0, 1));
         apply_stimulus(1, vec, d);
         wait_done(1, cycles);
         check("rnd_e_cycles_in_range", 72'(cycles >= 2 && cycles <= 9), 72'd1);
         check_output(1, "rnd_e", vec, d);
      end
      for (int i = 0; i < 8; i++) begin
         vec = rand_vec(2);
         d   = 1'($urandom_range(0, 1));
         apply_stimulus(2, vec, d);
         wait_done(2, cycles);
         check("rnd_f_latency", 72'(cycles), 72'd4);
         check_output(2, "rnd_f", vec, d);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
